// File: rtl/store_unit.sv
// Store path between execute and the AHB-Lite data bus: address-phase mask/HTRANS
// generation plus a registered, wait-state-tolerant data phase.
module store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  funct3_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic        mem_wr_req_in,
    input  logic        ahb_ready_in,
    output logic [31:0] d_addr_out,
    output logic [31:0] data_out,
    output logic [3:0]  wr_mask_out,
    output logic [1:0]  ahb_htrans_out,
    output logic        wr_req_out
);

    // Handshake: a transfer is accepted on a rising edge where mem_wr_req_in and
    // ahb_ready_in are both high; its data is driven in the following cycle and held
    // until ahb_ready_in is seen high again.

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic [1:0]  byte_sel;
    logic [3:0]  lane_mask;
    logic [31:0] aligned_data;
    logic        accept;

    logic [31:0] data_d,         data_q;
    logic        data_pending_d, data_pending_q;

    assign byte_sel = iadder_in[1:0];
    assign accept   = mem_wr_req_in & ahb_ready_in;

    // Lane selection; funct3 2'b11 is treated as a word store.
    always_comb begin
        lane_mask    = 4'b1111;
        aligned_data = rs2_in;
        case (funct3_in)
            2'b00: begin
                lane_mask    = 4'b0001 << byte_sel;
                aligned_data = {24'h0, rs2_in[7:0]} << {byte_sel, 3'b000};
            end
            2'b01: begin
                lane_mask    = byte_sel[1] ? 4'b1100 : 4'b0011;
                aligned_data = byte_sel[1] ? {rs2_in[15:0], 16'h0} : {16'h0, rs2_in[15:0]};
            end
            default: begin
                lane_mask    = 4'b1111;
                aligned_data = rs2_in;
            end
        endcase
    end

    always_comb begin
        d_addr_out     = 32'h0;
        wr_mask_out    = 4'b0000;
        ahb_htrans_out = HTRANS_IDLE;
        wr_req_out     = 1'b0;
        if (!reset) begin
            d_addr_out     = {iadder_in[31:2], 2'b00};
            wr_mask_out    = mem_wr_req_in ? lane_mask : 4'b0000;
            ahb_htrans_out = accept ? HTRANS_NONSEQ : HTRANS_IDLE;
            wr_req_out     = mem_wr_req_in;
        end
    end

    // A low HREADY stretches the current data phase, so everything holds.
    always_comb begin
        data_d         = data_q;
        data_pending_d = data_pending_q;
        if (ahb_ready_in) begin
            data_pending_d = accept;
            if (accept) begin
                data_d = aligned_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q         <= 32'h0;
            data_pending_q <= 1'b0;
        end else begin
            data_q         <= data_d;
            data_pending_q <= data_pending_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: address-phase outputs, lane alignment, wait states,
// back-to-back transfers, idle cycles and reset during a data phase.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  funct3_in;
    logic [31:0] iadder_in;
    logic [31:0] rs2_in;
    logic        mem_wr_req_in;
    logic        ahb_ready_in;
    logic [31:0] d_addr_out;
    logic [31:0] data_out;
    logic [3:0]  wr_mask_out;
    logic [1:0]  ahb_htrans_out;
    logic        wr_req_out;

    int checks = 0;
    int errors = 0;

    store_unit dut (
        .clk           (clk),
        .reset         (reset),
        .funct3_in     (funct3_in),
        .iadder_in     (iadder_in),
        .rs2_in        (rs2_in),
        .mem_wr_req_in (mem_wr_req_in),
        .ahb_ready_in  (ahb_ready_in),
        .d_addr_out    (d_addr_out),
        .data_out      (data_out),
        .wr_mask_out   (wr_mask_out),
        .ahb_htrans_out(ahb_htrans_out),
        .wr_req_out    (wr_req_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [1:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic req, input logic rdy);
        funct3_in     = f3;
        iadder_in     = addr;
        rs2_in        = rs2;
        mem_wr_req_in = req;
        ahb_ready_in  = rdy;
        #1;
    endtask

    task automatic check_addr_phase(input string tag, input logic [31:0] exp_addr,
                                    input logic [3:0] exp_mask, input logic [1:0] exp_htrans,
                                    input logic exp_req);
        check({tag, "_addr"},   d_addr_out,            exp_addr);
        check({tag, "_mask"},   {28'h0, wr_mask_out},  {28'h0, exp_mask});
        check({tag, "_htrans"}, {30'h0, ahb_htrans_out}, {30'h0, exp_htrans});
        check({tag, "_wrreq"},  {31'h0, wr_req_out},   {31'h0, exp_req});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with an active request: everything forced low.
        reset = 1'b1;
        drive(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        check_addr_phase("rst", 32'h0, 4'b0000, 2'b00, 1'b0);
        tick;
        tick;
        check("rst_data", data_out, 32'h0);
        check_addr_phase("rst2", 32'h0, 4'b0000, 2'b00, 1'b0);

        reset = 1'b0;

        // SB lane 0
        drive(2'b00, 32'h0000_1000, 32'h0000_00A5, 1'b1, 1'b1);
        check_addr_phase("sb0", 32'h0000_1000, 4'b0001, 2'b10, 1'b1);
        tick;
        check("sb0_data", data_out, 32'h0000_00A5);

        // SB lane 3
        drive(2'b00, 32'h0000_1003, 32'h1234_5678, 1'b1, 1'b1);
        check_addr_phase("sb3", 32'h0000_1000, 4'b1000, 2'b10, 1'b1);
        tick;
        check("sb3_data", data_out, 32'h7800_0000);

        // SB lane 1
        drive(2'b00, 32'h0000_1001, 32'h1234_5678, 1'b1, 1'b1);
        check_addr_phase("sb1", 32'h0000_1000, 4'b0010, 2'b10, 1'b1);
        tick;
        check("sb1_data", data_out, 32'h0000_7800);

        // SH upper half
        drive(2'b01, 32'h0000_2002, 32'h1234_5678, 1'b1, 1'b1);
        check_addr_phase("shu", 32'h0000_2000, 4'b1100, 2'b10, 1'b1);
        tick;
        check("shu_data", data_out, 32'h5678_0000);

        // SH lower half, misaligned a[0] ignored
        drive(2'b01, 32'h0000_2001, 32'h1234_5678, 1'b1, 1'b1);
        check_addr_phase("shl", 32'h0000_2000, 4'b0011, 2'b10, 1'b1);
        tick;
        check("shl_data", data_out, 32'h0000_5678);

        // SW with ignored low bits
        drive(2'b10, 32'h0000_3001, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check_addr_phase("sw", 32'h0000_3000, 4'b1111, 2'b10, 1'b1);
        tick;
        check("sw_data", data_out, 32'hDEAD_BEEF);

        // funct3 11 behaves as word
        drive(2'b11, 32'h0000_4003, 32'hCAFE_F00D, 1'b1, 1'b1);
        check_addr_phase("sw11", 32'h0000_4000, 4'b1111, 2'b10, 1'b1);
        tick;
        check("sw11_data", data_out, 32'hCAFE_F00D);

        // Wait states: accept, then hold data for 3 cycles of ready=0
        drive(2'b10, 32'h0000_5000, 32'h1111_1111, 1'b1, 1'b1);
        tick;
        check("ws_accept", data_out, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 32'h0000_5004, 32'h2222_2222 + i, 1'b1, 1'b0);
            check_addr_phase("ws_hold", 32'h0000_5004, 4'b1111, 2'b00, 1'b1);
            tick;
            check("ws_data", data_out, 32'h1111_1111);
        end
        // Data phase completes without a new request
        drive(2'b10, 32'h0000_5004, 32'h3333_3333, 1'b0, 1'b1);
        tick;
        check("ws_done", data_out, 32'h1111_1111);

        // Back-to-back byte stores
        drive(2'b00, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
        tick;
        check("b2b_1", data_out, 32'h0000_0001);
        drive(2'b00, 32'h0000_0000, 32'h0000_0002, 1'b1, 1'b1);
        tick;
        check("b2b_2", data_out, 32'h0000_0002);

        // No request
        drive(2'b10, 32'h0000_6000, 32'h9999_9999, 1'b0, 1'b1);
        check_addr_phase("idle", 32'h0000_6000, 4'b0000, 2'b00, 1'b0);
        tick;
        check("idle_data", data_out, 32'h0000_0002);

        // Reset during a wait-stated data phase
        drive(2'b10, 32'h0000_7000, 32'hAAAA_AAAA, 1'b1, 1'b1);
        tick;
        check("rmid_accept", data_out, 32'hAAAA_AAAA);
        drive(2'b10, 32'h0000_7000, 32'hBBBB_BBBB, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check_addr_phase("rmid", 32'h0, 4'b0000, 2'b00, 1'b0);
        tick;
        check("rmid_data", data_out, 32'h0);
        reset = 1'b0;
        drive(2'b10, 32'h0000_7000, 32'hBBBB_BBBB, 1'b0, 1'b1);
        tick;
        check("rmid_after", data_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
